spm_host_port_arb: RTL and testbench

N-requester arbiter for the host-side SPM port. It generalises the fixed two-way AXI read/write mux in front of the SPM to NUM_REQ requesters, for example AXI read/write engines, the encoder, and a future DMA. It offers selectable fixed-priority or round-robin arbitration, a registered SPM command stage, and in-order read-data return tagged to the issuing requester. It sits between the host-side engines and the SPM's single shared host port.

---
 rtl/spm_host_port_arb.sv | 134 +++++++++++++
 tb/tb_spm_host_port_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/spm_host_port_arb.sv
// Arbitrates NUM_REQ host-side requesters onto the single SPM host port.
// Provides a registered command stage and returns read data tagged to the issuing requester.
module spm_host_port_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 512,
  parameter int NB_PIPE    = 3,
  parameter int ARB_MODE   = 1,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(NB_PIPE + 2)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ-1:0]               i_req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_wdata,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic                             i_hold,
  output logic                             o_spm_en,
  output logic                             o_spm_wr_en,
  output logic [ADDR_WIDTH-1:0]            o_spm_addr,
  output logic [DATA_WIDTH-1:0]            o_spm_wr_data,
  input  logic [DATA_WIDTH-1:0]            i_spm_rd_data,
  output logic [NUM_REQ-1:0]               o_rsp_valid,
  output logic [DATA_WIDTH-1:0]            o_rsp_data,
  output logic [CNT_W-1:0]                 o_rd_outstanding,
  output logic                             o_busy
);

  typedef struct packed {
    logic                vld;
    logic [ID_WIDTH-1:0] id;
  } tag_t;

  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  spm_en_q, spm_en_d;
  logic                  spm_wr_en_q, spm_wr_en_d;
  logic [ADDR_WIDTH-1:0] spm_addr_q, spm_addr_d;
  logic [DATA_WIDTH-1:0] spm_wr_data_q, spm_wr_data_d;
  logic [ID_WIDTH-1:0]   spm_id_q, spm_id_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  tag_t                  tag_q [NB_PIPE];
  tag_t                  tag_d [NB_PIPE];

  logic                  gnt_found;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic [ID_WIDTH-1:0]   cand;
  logic                  rd_acc;
  logic                  rsp_fire;

  // Grant search: round-robin starts at rr_ptr and wraps, fixed priority starts at 0.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    gnt_found   = 1'b0;
    gnt_id      = '0;
    cand        = '0;
    o_req_ready = '0;
    if (!rst && !i_hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ARB_MODE == 1) cand = ID_WIDTH'((int'(rr_ptr_q) + i) % NUM_REQ);
        else               cand = ID_WIDTH'(i);
        if (!gnt_found && i_req_valid[cand]) begin
          gnt_found = 1'b1;
          gnt_id    = cand;
        end
      end
    end
    if (gnt_found) o_req_ready[gnt_id] = 1'b1;
  end

  assign rd_acc   = gnt_found & ~i_req_we[gnt_id];
  assign rsp_fire = tag_q[NB_PIPE-1].vld;

  always_comb begin
    spm_en_d      = gnt_found;
    spm_wr_en_d   = gnt_found & i_req_we[gnt_id];
    spm_addr_d    = spm_addr_q;
    spm_wr_data_d = spm_wr_data_q;
    spm_id_d      = spm_id_q;
    rr_ptr_d      = rr_ptr_q;
    if (gnt_found) begin
      spm_addr_d    = i_req_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];
      spm_wr_data_d = i_req_wdata[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
      spm_id_d      = gnt_id;
      rr_ptr_d      = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
    rd_cnt_d = rd_cnt_q + CNT_W'(rd_acc) - CNT_W'(rsp_fire);
  end

  // Tag pipe captures reads on the command cycle so its tail lines up with SPM read data.
  always_comb begin
    tag_d[0] = '{vld: spm_en_q & ~spm_wr_en_q, id: spm_id_q};
    for (int i = 1; i < NB_PIPE; i++) tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      rr_ptr_q      <= '0;
      spm_en_q      <= 1'b0;
      spm_wr_en_q   <= 1'b0;
      spm_addr_q    <= '0;
      spm_wr_data_q <= '0;
      spm_id_q      <= '0;
      rd_cnt_q      <= '0;
      // NOTE: the tag pipe is reset so reads in flight at reset never produce a response.
      for (int i = 0; i < NB_PIPE; i++) tag_q[i] <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      spm_en_q      <= spm_en_d;
      spm_wr_en_q   <= spm_wr_en_d;
      spm_addr_q    <= spm_addr_d;
      spm_wr_data_q <= spm_wr_data_d;
      spm_id_q      <= spm_id_d;
      rd_cnt_q      <= rd_cnt_d;
      for (int i = 0; i < NB_PIPE; i++) tag_q[i] <= tag_d[i];
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    if (rsp_fire) o_rsp_valid[tag_q[NB_PIPE-1].id] = 1'b1;
  end

  assign o_spm_en         = spm_en_q;
  assign o_spm_wr_en      = spm_wr_en_q;
  assign o_spm_addr       = spm_addr_q;
  assign o_spm_wr_data    = spm_wr_data_q;
  assign o_rsp_data       = i_spm_rd_data;
  assign o_rd_outstanding = rd_cnt_q;
  assign o_busy           = (rd_cnt_q != '0) | spm_en_q;

endmodule

// File: tb/tb_spm_host_port_arb.sv
// Directed bench for spm_host_port_arb: round-robin instance plus a fixed-priority
// instance on shared stimulus, with a 3-cycle SPM read model.
module tb_spm_host_port_arb;

  localparam int NR = 4;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int NP = 3;
  localparam int CW = $clog2(NP + 2);

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic            hold;
  logic [DW-1:0]   spm_rd_data;

  logic [NR-1:0]   ready, rsp_valid;
  logic            spm_en, spm_wr_en, busy;
  logic [AW-1:0]   spm_addr;
  logic [DW-1:0]   spm_wr_data, rsp_data;
  logic [CW-1:0]   rd_out;

  logic [NR-1:0]   fp_ready, fp_rsp_valid;
  logic            fp_spm_en, fp_spm_wr_en, fp_busy;
  logic [AW-1:0]   fp_spm_addr;
  logic [DW-1:0]   fp_spm_wr_data, fp_rsp_data;
  logic [CW-1:0]   fp_rd_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spm_host_port_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_PIPE(NP), .ARB_MODE(1)) dut (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_req_ready(ready), .i_hold(hold), .o_spm_en(spm_en),
    .o_spm_wr_en(spm_wr_en), .o_spm_addr(spm_addr), .o_spm_wr_data(spm_wr_data),
    .i_spm_rd_data(spm_rd_data), .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_rd_outstanding(rd_out), .o_busy(busy)
  );

  spm_host_port_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_PIPE(NP), .ARB_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_we(req_we), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_req_ready(fp_ready), .i_hold(hold), .o_spm_en(fp_spm_en),
    .o_spm_wr_en(fp_spm_wr_en), .o_spm_addr(fp_spm_addr), .o_spm_wr_data(fp_spm_wr_data),
    .i_spm_rd_data(spm_rd_data), .o_rsp_valid(fp_rsp_valid), .o_rsp_data(fp_rsp_data),
    .o_rd_outstanding(fp_rd_out), .o_busy(fp_busy)
  );

  // SPM model driven by the round-robin instance; unwritten words read as 0xDEAD0000 | addr.
  logic [DW-1:0] mem [int];
  logic [DW-1:0] rd_pipe [NP];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : (32'hDEAD_0000 | DW'(a));
  endfunction

  always @(posedge clk) begin
    if (spm_en && spm_wr_en) mem[int'(spm_addr)] = spm_wr_data;
    rd_pipe[0] <= (spm_en && !spm_wr_en) ? mem_rd(spm_addr) : '0;
    for (int i = 1; i < NP; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign spm_rd_data = rd_pipe[NP-1];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[k]          = v;
    req_we[k]             = we;
    req_addr[k*AW +: AW]  = a;
    req_wdata[k*DW +: DW] = d;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && busy; i++) step();
    check("drain_idle", 64'(busy), 64'd0);
  endtask

  logic [NR-1:0] rr_seq [7];
  logic [AW-1:0] a_exp;

  initial begin
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b1000; rr_seq[3] = 4'b0001;
    rr_seq[4] = 4'b0010; rr_seq[5] = 4'b1000; rr_seq[6] = 4'b0010;
    for (int i = 0; i < NP; i++) rd_pipe[i] = '0;
    rst = 1'b1; hold = 1'b0;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

    // Reset: ready suppressed even with a valid request, all outputs zero.
    step(); set_req(0, 1'b1, 1'b0, 14'h0, 32'h0); step(); #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_en", 64'(spm_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out", 64'(rd_out), 64'd0);
    check("rst_rsp", 64'(rsp_valid), 64'd0);
    req_valid = '0;
    step(); rst = 1'b0;

    // Round-robin vs fixed priority: 0,1,3 valid for 6 cycles, then 1,3 only.
    for (int k = 0; k < NR; k++) set_req(k, k != 2, 1'b0, AW'(16 + k), 32'h0);
    for (int c = 0; c < 11; c++) begin
      if (c == 6) req_valid = 4'b1010;
      if (c == 7) req_valid = '0;
      #1;
      if (c < 7) begin
        check($sformatf("rr_gnt_%0d", c), 64'(ready), 64'(rr_seq[c]));
        check($sformatf("fp_gnt_%0d", c), 64'(fp_ready), (c < 6) ? 64'd1 : 64'd2);
      end
      if (c == 4 || c == 5) check($sformatf("rr_outst_%0d", c), 64'(rd_out), 64'(NP + 1));
      if (c >= 4) begin
        check($sformatf("rr_rsp_%0d", c), 64'(rsp_valid), 64'(rr_seq[c-4]));
        a_exp = (rr_seq[c-4] == 4'b0001) ? 14'd16 : (rr_seq[c-4] == 4'b0010) ? 14'd17 : 14'd19;
        check($sformatf("rr_data_%0d", c), 64'(rsp_data), 64'(32'hDEAD_0000 | 32'(a_exp)));
      end
      step();
    end
    drain();

    // Single read by requester 2 of address 0x0A5.
    set_req(2, 1'b1, 1'b0, 14'h0A5, 32'h0); #1;
    check("rd_gnt", 64'(ready), 64'b0100);
    step(); req_valid = '0; #1;
    check("rd_en", 64'(spm_en), 64'd1);
    check("rd_we", 64'(spm_wr_en), 64'd0);
    check("rd_addr", 64'(spm_addr), 64'h0A5);
    check("rd_outst1", 64'(rd_out), 64'd1);
    step(); #1; check("rd_en_off", 64'(spm_en), 64'd0);
    step(); #1; check("rd_rsp_early", 64'(rsp_valid), 64'd0);
    step(); #1;
    check("rd_rsp", 64'(rsp_valid), 64'b0100);
    check("rd_data", 64'(rsp_data), 64'hDEAD_00A5);
    check("rd_outst_last", 64'(rd_out), 64'd1);
    step(); #1;
    check("rd_outst0", 64'(rd_out), 64'd0);
    check("rd_rsp_off", 64'(rsp_valid), 64'd0);
    check("rd_busy_off", 64'(busy), 64'd0);

    // Write then read the same address from requester 1.
    set_req(1, 1'b1, 1'b1, 14'd7, 32'h1234); #1;
    check("wr_gnt", 64'(ready), 64'b0010);
    step(); set_req(1, 1'b1, 1'b0, 14'd7, 32'h0); #1;
    check("wr_we", 64'(spm_wr_en), 64'd1);
    check("wr_wdata", 64'(spm_wr_data), 64'h1234);
    check("wr_rd_gnt", 64'(ready), 64'b0010);
    step(); req_valid = '0; #1;
    check("wr_rd_en", 64'(spm_en), 64'd1);
    check("wr_rd_we", 64'(spm_wr_en), 64'd0);
    step(); step(); #1;
    check("wr_no_rsp", 64'(rsp_valid), 64'd0);
    step(); #1;
    check("wr_rd_rsp", 64'(rsp_valid), 64'b0010);
    check("wr_rd_data", 64'(rsp_data), 64'h1234);
    drain();

    // Hold with two reads in flight; rr_ptr is 2 here.
    set_req(0, 1'b1, 1'b0, 14'd40, 32'h0); #1;
    check("hd_gnt0", 64'(ready), 64'b0001);
    step(); req_valid = '0; set_req(3, 1'b1, 1'b0, 14'd43, 32'h0); #1;
    check("hd_gnt3", 64'(ready), 64'b1000);
    step(); req_valid = 4'b0110; hold = 1'b1; #1;
    check("hd_ready", 64'(ready), 64'd0);
    check("hd_fp_ready", 64'(fp_ready), 64'd0);
    check("hd_outst", 64'(rd_out), 64'd2);
    step(); #1; check("hd_ready2", 64'(ready), 64'd0);
    step(); #1;
    check("hd_rsp0", 64'(rsp_valid), 64'b0001);
    check("hd_data0", 64'(rsp_data), 64'hDEAD_0028);
    step(); #1;
    check("hd_rsp3", 64'(rsp_valid), 64'b1000);
    check("hd_busy_last", 64'(busy), 64'd1);
    step(); #1;
    check("hd_busy_off", 64'(busy), 64'd0);
    hold = 1'b0; #1;
    check("hd_resume", 64'(ready), 64'b0010);
    step(); req_valid = 4'b0100; #1;
    check("hd_resume2", 64'(ready), 64'b0100);
    step(); req_valid = '0;
    drain();

    // Reset two cycles after a read accept; rr_ptr is 3 here.
    set_req(0, 1'b1, 1'b0, 14'd50, 32'h0); #1;
    check("rs_gnt", 64'(ready), 64'b0001);
    step(); req_valid = '0;
    step(); rst = 1'b1; set_req(3, 1'b1, 1'b1, 14'd60, 32'h55); #1;
    check("rs_ready_in_rst", 64'(ready), 64'd0);
    step(); rst = 1'b0; req_valid = 4'b1001; #1;
    check("rs_en", 64'(spm_en), 64'd0);
    check("rs_addr", 64'(spm_addr), 64'd0);
    check("rs_outst", 64'(rd_out), 64'd0);
    check("rs_busy", 64'(busy), 64'd0);
    check("rs_next_gnt", 64'(ready), 64'b0001);
    step(); req_valid = '0; #1;
    check("rs_no_rsp", 64'(rsp_valid), 64'd0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
